// File: rtl/npu_alu.sv
// npu_alu: two-stage elementwise ALU for the NPU local-memory datapath.
//
// A job is a run of NPU_EN cycles. Each NPU_EN cycle launches one element
// whose operands show up IN_LAT cycles later on A_RDATA/B_RDATA. Stage 1
// computes a 17-bit signed raw result. Stage 2 shifts it, saturates it to
// 8 bits, optionally applies RELU, and writes it out with LM_EN.
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   NPU_EN            launch one element this cycle
//   A_RDATA, B_RDATA  signed 8-bit operands, valid IN_LAT cycles after NPU_EN
//   OP, SHIFT, RELU_EN  job configuration, latched when a job starts
//   LM_EN, C_WDATA    result strobe and signed 8-bit result
//   BUSY              job in progress (RUN or DRAIN)
//   DONE              one-cycle pulse when the last result has been written
//   SAT_CNT           number of clipped results in the current job (sticky at 1023)

module npu_alu #(
    parameter int IN_LAT = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       NPU_EN,
    input  logic [7:0] A_RDATA,
    input  logic [7:0] B_RDATA,
    input  logic [2:0] OP,
    input  logic [2:0] SHIFT,
    input  logic       RELU_EN,
    output logic       LM_EN,
    output logic [7:0] C_WDATA,
    output logic       BUSY,
    output logic       DONE,
    output logic [9:0] SAT_CNT
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [2:0]         r_op;
    logic [2:0]         r_shift;
    logic               r_relu;
    logic               r_s1Valid;
    logic signed [16:0] r_s1Raw;
    logic               r_lmEn;
    logic [7:0]         r_cData;
    logic [9:0]         r_satCnt;

    logic               w_v0;
    logic               w_chainBusy;
    logic               w_start;
    logic               w_emptyNext;
    logic [2:0]         w_op;
    logic signed [16:0] w_aExt;
    logic signed [16:0] w_bExt;
    logic signed [16:0] w_mul;
    logic signed [16:0] w_raw;
    logic signed [16:0] w_shifted;
    logic               w_clip;
    logic [7:0]         w_sat8;
    logic [7:0]         w_res;

    // Operand-valid delay chain: v0 marks the cycle in which the operands of a
    // launched element are actually on A_RDATA/B_RDATA.
    generate
        if (IN_LAT == 0) begin : g_noLat
            assign w_v0        = NPU_EN;
            assign w_chainBusy = 1'b0;
        end else begin : g_lat
            logic [IN_LAT-1:0] r_vChain;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_vChain <= '0;
                end else begin
                    r_vChain[0] <= NPU_EN;
                    for (int i = 1; i < IN_LAT; i++) begin
                        r_vChain[i] <= r_vChain[i-1];
                    end
                end
            end

            assign w_v0        = r_vChain[IN_LAT-1];
            assign w_chainBusy = |r_vChain;
        end
    endgenerate

    assign w_start = (r_state == IDLE) && NPU_EN;

    // The job-start cycle has no latched config yet, so it runs on the live OP.
    assign w_op = (r_state == IDLE) ? OP : r_op;

    // After this edge nothing would be left in the chain or stage 1, so stage 2
    // is writing the last result of the job right now.
    assign w_emptyNext = !NPU_EN && !w_chainBusy && !r_s1Valid;

    assign w_aExt = {{9{A_RDATA[7]}}, A_RDATA};
    assign w_bExt = {{9{B_RDATA[7]}}, B_RDATA};
    // The full product (-16256..16384) fits in 17 signed bits, so the
    // truncated 17x17 product is exact.
    assign w_mul  = w_aExt * w_bExt;

    // Stage 1 operation select, all results sized to 17 bits without overflow.
    always_comb begin
        w_raw = w_bExt;
        case (w_op)
            3'b000:  w_raw = w_aExt + w_bExt;
            3'b001:  w_raw = w_aExt - w_bExt;
            3'b010:  w_raw = w_mul;
            3'b011:  w_raw = (w_aExt > w_bExt) ? w_aExt : w_bExt;
            3'b100:  w_raw = (w_aExt < w_bExt) ? w_aExt : w_bExt;
            3'b101:  w_raw = w_aExt;
            default: w_raw = w_bExt;
        endcase
    end

    // Stage 1 register: raw result of each element whose operands are valid.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s1Valid <= 1'b0;
            r_s1Raw   <= '0;
        end else begin
            r_s1Valid <= w_v0;
            if (w_v0) begin
                r_s1Raw <= w_raw;
            end
        end
    end

    // Floor shift, then clip to the 8-bit range; RELU comes after clipping so a
    // clipped negative still counts as saturated even though it ends up 0.
    assign w_shifted = r_s1Raw >>> r_shift;
    assign w_clip    = (w_shifted > 17'sd127) || (w_shifted < -17'sd128);

    always_comb begin
        w_sat8 = w_shifted[7:0];
        if (w_shifted > 17'sd127) begin
            w_sat8 = 8'h7F;
        end else if (w_shifted < -17'sd128) begin
            w_sat8 = 8'h80;
        end
    end

    assign w_res = (r_relu && w_sat8[7]) ? 8'h00 : w_sat8;

    // Stage 2 register: output strobe, held result data and the saturation
    // counter, which restarts with every new job and sticks at its maximum.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_lmEn   <= 1'b0;
            r_cData  <= '0;
            r_satCnt <= '0;
        end else begin
            r_lmEn <= r_s1Valid;
            if (r_s1Valid) begin
                r_cData <= w_res;
            end
            if (w_start) begin
                r_satCnt <= '0;
            end else if (r_s1Valid && w_clip && (r_satCnt != 10'd1023)) begin
                r_satCnt <= r_satCnt + 10'd1;
            end
        end
    end

    // Job-control FSM. A re-rise of NPU_EN while draining just resumes the
    // same job; config and SAT_CNT are only touched when leaving IDLE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_op    <= '0;
            r_shift <= '0;
            r_relu  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (NPU_EN) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_op    <= OP;
                        r_shift <= SHIFT;
                        r_relu  <= RELU_EN;
                    end
                end
                RUN: begin
                    if (!NPU_EN) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (NPU_EN) begin
                        r_state <= RUN;
                    end else if (w_emptyNext) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign LM_EN   = r_lmEn;
    assign C_WDATA = r_cData;
    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign SAT_CNT = r_satCnt;

endmodule

// File: tb/tb_npu_alu.sv
// tb_npu_alu: self-checking bench for npu_alu with IN_LAT=1.
//
// Single-element jobs come from a vector table of hand-computed results.
// Hand-written sequences cover the exact pipeline timing, a two-element
// saturating job, a 1024-element burst with a mid-job OP change, reset in the
// middle of a burst, and NPU_EN re-rising while the job drains.
// Expected results go into a scoreboard queue when an element is launched; a
// negedge monitor pops and compares one entry on every LM_EN.

module tb_npu_alu;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       NPU_EN;
    logic [7:0] A_RDATA;
    logic [7:0] B_RDATA;
    logic [2:0] OP;
    logic [2:0] SHIFT;
    logic       RELU_EN;
    logic       LM_EN;
    logic [7:0] C_WDATA;
    logic       BUSY;
    logic       DONE;
    logic [9:0] SAT_CNT;

    npu_alu #(.IN_LAT(1)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .NPU_EN  (NPU_EN),
        .A_RDATA (A_RDATA),
        .B_RDATA (B_RDATA),
        .OP      (OP),
        .SHIFT   (SHIFT),
        .RELU_EN (RELU_EN),
        .LM_EN   (LM_EN),
        .C_WDATA (C_WDATA),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .SAT_CNT (SAT_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        logic [9:0] sat;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [2:0] shift;
        logic       relu;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expData;
        logic [9:0] expSat;
    } vec_t;

    int   testsRun    = 0;
    int   testsFailed = 0;
    int   cyc         = 0;
    int   lmCount     = 0;
    int   doneCount   = 0;
    int   lastLmCyc   = -1;
    int   lastDoneCyc = -1;
    exp_t sbQ[$];
    exp_t monE;
    vec_t vecs[$];
    logic       jobEn[$];
    logic [7:0] jobA[$];
    logic [7:0] jobB[$];

    // Cycle counter: a cycle is numbered by the rising edge that starts it.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Scoreboard monitor, sampling away from the rising edge.
    always @(negedge CLK) begin
        if (LM_EN === 1'b1) begin
            lmCount++;
            lastLmCyc = cyc;
            if (sbQ.size() == 0) begin
                checkOutput("lmEnWithNothingPending", {31'b0, LM_EN}, 32'd0);
            end else begin
                monE = sbQ.pop_front();
                checkOutput("cWdata", {24'b0, C_WDATA}, {24'b0, monE.data});
                checkOutput("satCnt", {22'b0, SAT_CNT}, {22'b0, monE.sat});
            end
        end
        if (DONE === 1'b1) begin
            doneCount++;
            lastDoneCyc = cyc;
        end
    end

    task automatic pushExp(input logic [7:0] d, input logic [9:0] s);
        exp_t e;
        e.data = d;
        e.sat  = s;
        sbQ.push_back(e);
    endtask

    // Drive one cycle's inputs and advance to just after the next rising edge.
    task automatic applyStimulus(input logic en, input logic [7:0] a, input logic [7:0] b);
        NPU_EN  = en;
        A_RDATA = a;
        B_RDATA = b;
        @(posedge CLK);
        #1;
    endtask

    // Wait (bounded) until the job is finished and every result has arrived.
    task automatic waitIdle(input int maxWait);
        for (int k = 0; k < maxWait; k++) begin
            if (BUSY === 1'b0 && sbQ.size() == 0) break;
            @(posedge CLK);
            #1;
        end
        checkOutput("busyLowAfterJob", {31'b0, BUSY}, 32'd0);
        checkOutput("scoreboardDrained", sbQ.size(), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    // Play the queued NPU_EN pattern; operands follow one cycle after each
    // launch. OP is overwritten with chgOp at cycle chgCycle (if >= 0).
    task automatic runJob(input int chgCycle, input logic [2:0] chgOp, input int maxWait);
        int   n;
        logic en;
        n = jobEn.size();
        for (int i = 0; i <= n; i++) begin
            en = 1'b0;
            if (i < n) en = jobEn[i];
            if (i == chgCycle) OP = chgOp;
            if (i > 0 && jobEn[i-1]) applyStimulus(en, jobA.pop_front(), jobB.pop_front());
            else                     applyStimulus(en, 8'($urandom), 8'($urandom));
        end
        jobEn.delete();
        waitIdle(maxWait);
    endtask

    task automatic addVec(input logic [2:0] op, input logic [2:0] sh, input logic rl,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] d, input logic [9:0] s);
        vec_t v;
        v.op = op; v.shift = sh; v.relu = rl; v.a = a; v.b = b;
        v.expData = d; v.expSat = s;
        vecs.push_back(v);
    endtask

    // Single MUL element: result at launch+3, DONE at launch+4.
    task automatic runTimingJob();
        int t;
        int lm0;
        int d0;
        OP = 3'b010; SHIFT = 3'd2; RELU_EN = 1'b0;
        lm0 = lmCount; d0 = doneCount;
        t = cyc;
        jobEn.push_back(1'b1); jobA.push_back(8'd12); jobB.push_back(8'd10);
        pushExp(8'd30, 10'd0);
        runJob(-1, 3'b000, 20);
        checkOutput("timingLmCount", lmCount - lm0, 32'd1);
        checkOutput("timingLmCycle", lastLmCyc, t + 3);
        checkOutput("timingDoneCount", doneCount - d0, 32'd1);
        checkOutput("timingDoneCycle", lastDoneCyc, t + 4);
        checkOutput("cWdataHeld", {24'b0, C_WDATA}, 32'd30);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, testsRun %0d", testsRun);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lm0;
        int d0;
        logic [7:0] a;
        logic [7:0] b;

        // ADD  SUB  MUL  MAX  MIN  PASSA  PASSB: 0..6, 7 also PASSB
        addVec(3'd0, 3'd0, 1'b0, 8'd100, 8'd50,  8'h7F, 10'd1);
        addVec(3'd0, 3'd0, 1'b0, 8'h9C,  8'h9C,  8'h80, 10'd1);
        addVec(3'd1, 3'd0, 1'b1, 8'h9C,  8'd100, 8'h00, 10'd1);
        addVec(3'd2, 3'd2, 1'b0, 8'd20,  8'hE2,  8'h80, 10'd1);
        addVec(3'd2, 3'd2, 1'b0, 8'd12,  8'd10,  8'h1E, 10'd0);
        addVec(3'd3, 3'd0, 1'b0, 8'hFB,  8'h03,  8'h03, 10'd0);
        addVec(3'd4, 3'd0, 1'b0, 8'hFB,  8'h03,  8'hFB, 10'd0);
        addVec(3'd5, 3'd0, 1'b0, 8'h4D,  8'hFF,  8'h4D, 10'd0);
        addVec(3'd6, 3'd0, 1'b0, 8'h4D,  8'hFF,  8'hFF, 10'd0);
        addVec(3'd7, 3'd0, 1'b0, 8'h01,  8'h02,  8'h02, 10'd0);
        addVec(3'd1, 3'd0, 1'b0, 8'd10,  8'd3,   8'h07, 10'd0);
        addVec(3'd0, 3'd0, 1'b1, 8'hFD,  8'h01,  8'h00, 10'd0);
        addVec(3'd1, 3'd1, 1'b0, 8'h00,  8'h05,  8'hFD, 10'd0);
        addVec(3'd2, 3'd7, 1'b0, 8'h80,  8'h80,  8'h7F, 10'd1);
        addVec(3'd2, 3'd7, 1'b0, 8'h80,  8'h7F,  8'h81, 10'd0);
        addVec(3'd3, 3'd0, 1'b0, 8'h7F,  8'h80,  8'h7F, 10'd0);
        addVec(3'd4, 3'd0, 1'b0, 8'h7F,  8'h80,  8'h80, 10'd0);
        addVec(3'd0, 3'd1, 1'b0, 8'h7F,  8'h7F,  8'h7F, 10'd0);
        addVec(3'd0, 3'd0, 1'b1, 8'h7F,  8'h01,  8'h7F, 10'd1);
        addVec(3'd0, 3'd7, 1'b0, 8'h80,  8'h80,  8'hFE, 10'd0);
        addVec(3'd2, 3'd0, 1'b1, 8'h80,  8'h80,  8'h7F, 10'd1);

        RESET = 1'b1; NPU_EN = 1'b0; A_RDATA = '0; B_RDATA = '0;
        OP = '0; SHIFT = '0; RELU_EN = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        checkOutput("resetLmEn",   {31'b0, LM_EN},   32'd0);
        checkOutput("resetCWdata", {24'b0, C_WDATA}, 32'd0);
        checkOutput("resetBusy",   {31'b0, BUSY},    32'd0);
        checkOutput("resetDone",   {31'b0, DONE},    32'd0);
        checkOutput("resetSatCnt", {22'b0, SAT_CNT}, 32'd0);
        RESET = 1'b0;
        applyStimulus(1'b0, 8'd0, 8'd0);

        runTimingJob();

        // Table of single-element jobs.
        foreach (vecs[i]) begin
            OP = vecs[i].op; SHIFT = vecs[i].shift; RELU_EN = vecs[i].relu;
            lm0 = lmCount; d0 = doneCount;
            jobEn.push_back(1'b1); jobA.push_back(vecs[i].a); jobB.push_back(vecs[i].b);
            pushExp(vecs[i].expData, vecs[i].expSat);
            runJob(-1, 3'b000, 20);
            checkOutput("vecLmCount",   lmCount - lm0,   32'd1);
            checkOutput("vecDoneCount", doneCount - d0,  32'd1);
        end

        // Two saturating ADDs in one job: SAT_CNT accumulates.
        OP = 3'd0; SHIFT = 3'd0; RELU_EN = 1'b0;
        jobEn.push_back(1'b1); jobA.push_back(8'd100); jobB.push_back(8'd50);
        jobEn.push_back(1'b1); jobA.push_back(8'h9C);  jobB.push_back(8'h9C);
        pushExp(8'h7F, 10'd1);
        pushExp(8'h80, 10'd2);
        runJob(-1, 3'b000, 20);

        // 1024-element ADD burst; live OP switches to MIN at element 500.
        OP = 3'd0; SHIFT = 3'd0; RELU_EN = 1'b0;
        lm0 = lmCount; d0 = doneCount;
        for (int i = 0; i < 1024; i++) begin
            a = 8'(i % 64);
            b = 8'((i % 32) - 16);
            jobEn.push_back(1'b1); jobA.push_back(a); jobB.push_back(b);
            pushExp(a + b, 10'd0);
        end
        runJob(500, 3'd4, 40);
        checkOutput("burstLmCount",   lmCount - lm0,  32'd1024);
        checkOutput("burstDoneCount", doneCount - d0, 32'd1);

        // Reset in the middle of a saturating burst.
        OP = 3'd0; SHIFT = 3'd0; RELU_EN = 1'b0;
        lm0 = lmCount; d0 = doneCount;
        pushExp(8'h7F, 10'd1); applyStimulus(1'b1, 8'd0,   8'd0);
        pushExp(8'h7F, 10'd2); applyStimulus(1'b1, 8'd100, 8'd100);
        pushExp(8'h7F, 10'd3); applyStimulus(1'b1, 8'd100, 8'd100);
        pushExp(8'h7F, 10'd4); applyStimulus(1'b1, 8'd100, 8'd100);
        RESET = 1'b1;
        applyStimulus(1'b0, 8'd100, 8'd100);
        RESET = 1'b0;
        sbQ.delete();
        checkOutput("midResetLmEn",   {31'b0, LM_EN},   32'd0);
        checkOutput("midResetBusy",   {31'b0, BUSY},    32'd0);
        checkOutput("midResetSatCnt", {22'b0, SAT_CNT}, 32'd0);
        checkOutput("midResetDone",   {31'b0, DONE},    32'd0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'd0, 8'd0);
        checkOutput("midResetLmCount",   lmCount - lm0,  32'd2);
        checkOutput("midResetDoneCount", doneCount - d0, 32'd0);
        runTimingJob();

        // NPU_EN drops, then re-rises while draining; OP change there is ignored.
        OP = 3'd0; SHIFT = 3'd0; RELU_EN = 1'b0;
        lm0 = lmCount; d0 = doneCount;
        jobEn.push_back(1'b1); jobA.push_back(8'd100); jobB.push_back(8'd100);
        jobEn.push_back(1'b1); jobA.push_back(8'd100); jobB.push_back(8'd100);
        jobEn.push_back(1'b0);
        jobEn.push_back(1'b0);
        jobEn.push_back(1'b1); jobA.push_back(8'd100); jobB.push_back(8'd100);
        pushExp(8'h7F, 10'd1);
        pushExp(8'h7F, 10'd2);
        pushExp(8'h7F, 10'd3);
        runJob(4, 3'd1, 20);
        checkOutput("resumeLmCount",   lmCount - lm0,  32'd3);
        checkOutput("resumeDoneCount", doneCount - d0, 32'd1);
        checkOutput("resumeDoneCycle", lastDoneCyc, lastLmCyc + 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
